multi_cycle_core: RTL
=====================

MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath, PC and register width (16..64).
REQ-002 SHALL have parameter NREG, default 32, meaning register count (8, 16 or 32); RW = clog2(NREG).
REQ-003 SHALL have parameter PC_RESET, default 0, meaning PC value after reset.
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 run  in  1  high = fetch permitted
 imem_req  out  1  instruction fetch request
 imem_addr  out  XLEN  fetch address (= pc)
 imem_ack  in  1  instruction valid this cycle
 imem_rdata  in  32  instruction word
 pc  out  XLEN  current program counter
 retire  out  1  one-cycle pulse per completed instruction
 hata  out  1  sticky error flag
 dbg_addr  in  RW  debug register-read index
 dbg_data  out  XLEN  combinational read of register dbg_addr

Function
REQ-005 SHALL execute one instruction at a time through states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, ERROR.
REQ-006 IDLE: go to FETCH when run=1; otherwise stay.
REQ-007 FETCH: imem_req=1 and imem_addr=pc every cycle until imem_ack=1; latch imem_rdata on the ack cycle, then go to DECODE. An ack with imem_req=0 SHALL be ignored.
REQ-008 DECODE: opcode = instr[6:0]: 0000001 R, 0000011 I, 0000111 U, 0001111 B. Any other opcode SHALL go to ERROR.
REQ-009 Register fields: rs1 = [19:15], rs2 = [24:20], rd = [11:7]. A used field with a non-zero bit above RW-1 SHALL go to ERROR.
REQ-010 Immediates, zero-extended to XLEN:
 I: instr[31:20]
 U: instr[31:12] in bits [19:0]
 B: {instr[31:25], instr[11:7], 1'b0} in bits [12:0]
REQ-011 ALU op = funct3 = instr[14:12], applied to rs1 and rs2 (R) or rs1 and imm (I):
 000 add, 001 sub, 010 and, 011 or, 100 xor
 101 sll, 110 srl, 111 unsigned slt
 Shift amount = low clog2(XLEN) bits of operand 2. Results wrap modulo 2^XLEN.
REQ-012 U: result = imm.
REQ-013 B conditions on funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge; any other funct3 SHALL go to ERROR.
REQ-014 EXECUTE SHALL take exactly one cycle, then go to WRITEBACK.
REQ-015 WRITEBACK for R/I/U: write the result to rd unless rd=0. Register 0 SHALL always read 0.
REQ-016 WRITEBACK PC update: taken branch pc <= pc+imm; otherwise pc <= pc+4; both modulo 2^XLEN.
REQ-017 WRITEBACK SHALL pulse retire=1 for one cycle, then go to FETCH if run=1, else IDLE.
REQ-018 run is sampled only in IDLE and WRITEBACK; deasserting run mid-instruction SHALL NOT abort that instruction.
REQ-019 Minimum latency SHALL be 4 cycles per instruction with same-cycle ack; each ack-wait cycle adds one.
REQ-020 Register reads in DECODE SHALL see the write from the previous instruction's WRITEBACK (no forwarding needed).
REQ-021 ERROR: hata=1, imem_req=0, no register or PC writes, no retire; stay until reset.
REQ-022 dbg_data SHALL be a combinational read of register dbg_addr, independent of state; dbg_addr=0 returns 0.

Reset
REQ-023 reset=0 SHALL asynchronously force: state IDLE, pc=PC_RESET, hata=0, retire=0, imem_req=0, all registers 0, latched instruction 0.
REQ-024 Reset asserted mid-fetch or mid-writeback SHALL discard the instruction with no partial register write.
REQ-025 After release, the first fetch SHALL start on the first rising edge with run=1.

Structure
REQ-026 Package core_pkg SHALL hold: opcode constants, state enum, ALU-op enum, branch-condition constants.
REQ-027 The register file SHALL be sub-module core_regfile (NREG x XLEN, two read ports plus a debug read port, one write port, reg 0 hard zero); the FSM, decode, ALU and PC logic stay in multi_cycle_core.

Verification
REQ-028 Fetch 0x00500083 (I, add, rd=1, rs1=0, imm=5), ack same cycle -> retire on 4th cycle after IDLE exit, x1=5, pc=4.
REQ-029 x1=7, x2=3, R sub rd=3 -> x3=4. With XLEN=16: x1=0, x2=1, sub -> x3=0xFFFF (wrap).
REQ-030 B eq, x1=x2, imm=8 at pc=0x10 -> pc=0x18, no register change. Same instruction with x1!=x2 -> pc=0x14.
REQ-031 Opcode 0x33, or NREG=8 with rd=9 -> hata=1 after DECODE, imem_req stays 0, registers unchanged; reset clears hata.
REQ-032 imem_ack delayed 3 cycles, then run=0 during EXECUTE -> instruction retires (latency 7), core enters IDLE; pulse reset=0 mid-FETCH -> pc=PC_RESET immediately.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for multi_cycle_core and its register file:
//   - opcode constants for the four instruction classes (R, I, U, B)
//   - controller state enum
//   - ALU operation enum (encoded directly by funct3)
//   - branch-condition constants (funct3 values for B instructions)
//   - small decode helpers
// No ports: compile-time definitions only.
// -----------------------------------------------------------------------------
package core_pkg;

    // Opcode field instr[6:0]
    localparam logic [6:0] OPC_R = 7'b0000001;
    localparam logic [6:0] OPC_I = 7'b0000011;
    localparam logic [6:0] OPC_U = 7'b0000111;
    localparam logic [6:0] OPC_B = 7'b0001111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

    // funct3 selects the ALU operation for R and I instructions
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_SRL  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_e;

    // funct3 values that are legal for B instructions
    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    // A 5-bit register field is usable only if every bit above rw-1 is zero.
    function automatic logic reg_field_ok(input logic [4:0] field, input int rw);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i >= rw && field[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic br_funct_ok(input logic [2:0] funct3);
        return (funct3 == BR_EQ) || (funct3 == BR_NE) ||
               (funct3 == BR_LT) || (funct3 == BR_GE);
    endfunction

endpackage

// File: rtl/core_regfile.sv
// -----------------------------------------------------------------------------
// core_regfile
// NREG x XLEN register file, register 0 hard-wired to zero.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   we, waddr, wdata  single write port (writes to register 0 are dropped)
//   raddr1 / rdata1   combinational read port 1
//   raddr2 / rdata2   combinational read port 2
//   dbg_addr/dbg_data combinational debug read port
// -----------------------------------------------------------------------------
module core_regfile
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [RW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREG];

    // NOTE: the array is built from flops and every entry is reset, because
    // all architectural registers must read zero after reset; a RAM macro
    // could not be cleared this way.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Register 0 is forced to zero on every read port.
    assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/multi_cycle_core.sv
// -----------------------------------------------------------------------------
// multi_cycle_core
// Non-pipelined core: each instruction walks IDLE/FETCH -> DECODE -> EXECUTE
// -> WRITEBACK; illegal encodings park the core in ERROR until reset.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   run                   fetch permitted (sampled in IDLE and WRITEBACK)
//   imem_req, imem_addr   fetch request and address (= pc)
//   imem_ack, imem_rdata  fetch response; word is valid in the ack cycle
//   pc                    current program counter
//   retire                one-cycle pulse per completed instruction
//   hata                  sticky error flag
//   dbg_addr, dbg_data    combinational debug register read
// -----------------------------------------------------------------------------
module multi_cycle_core
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    localparam int             RW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            hata,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int SHW = $clog2(XLEN);

    state_e          state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [XLEN-1:0] result_q;
    logic            taken_q;

    // ---------------------------------------------------------------- decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1_f, rs2_f, rd_f;
    logic       is_r, is_i, is_u, is_b;
    logic       dec_err;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign rs1_f  = instr_q[19:15];
    assign rs2_f  = instr_q[24:20];
    assign rd_f   = instr_q[11:7];

    assign is_r = (opcode == OPC_R);
    assign is_i = (opcode == OPC_I);
    assign is_u = (opcode == OPC_U);
    assign is_b = (opcode == OPC_B);

    // Only the fields an instruction class actually uses are range-checked.
    // NOTE: every output of an always_comb gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        dec_err = 1'b0;
        case (opcode)
            OPC_R:   dec_err = !(reg_field_ok(rs1_f, RW) && reg_field_ok(rs2_f, RW) &&
                                 reg_field_ok(rd_f, RW));
            OPC_I:   dec_err = !(reg_field_ok(rs1_f, RW) && reg_field_ok(rd_f, RW));
            OPC_U:   dec_err = !reg_field_ok(rd_f, RW);
            OPC_B:   dec_err = !(reg_field_ok(rs1_f, RW) && reg_field_ok(rs2_f, RW) &&
                                 br_funct_ok(funct3));
            default: dec_err = 1'b1;
        endcase
    end

    // Zero-extended immediates; the size casts also truncate U for XLEN < 20.
    logic [XLEN-1:0] imm;

    always_comb begin
        imm = '0;
        if (is_i) begin
            imm = XLEN'(instr_q[31:20]);
        end else if (is_u) begin
            imm = XLEN'(instr_q[31:12]);
        end else if (is_b) begin
            imm = XLEN'({instr_q[31:25], instr_q[11:7], 1'b0});
        end
    end

    // ---------------------------------------------------------- register file
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rf_we;

    // Write happens on the edge that leaves WRITEBACK, so a reset that lands
    // inside WRITEBACK wins and nothing is written.
    assign rf_we = (state == ST_WRITEBACK) && (is_r || is_i || is_u);

    core_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rd_f[RW-1:0]),
        .wdata    (result_q),
        .raddr1   (rs1_f[RW-1:0]),
        .rdata1   (rs1_data),
        .raddr2   (rs2_f[RW-1:0]),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // -------------------------------------------------------- ALU and branch
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] exec_result;
    logic            br_taken;

    assign op2 = is_i ? imm : op_b_q;

    always_comb begin
        alu_res = op_a_q + op2;
        case (alu_op_e'(funct3))
            ALU_ADD:  alu_res = op_a_q + op2;
            ALU_SUB:  alu_res = op_a_q - op2;
            ALU_AND:  alu_res = op_a_q & op2;
            ALU_OR:   alu_res = op_a_q | op2;
            ALU_XOR:  alu_res = op_a_q ^ op2;
            ALU_SLL:  alu_res = op_a_q << op2[SHW-1:0];
            ALU_SRL:  alu_res = op_a_q >> op2[SHW-1:0];
            ALU_SLTU: alu_res = XLEN'(op_a_q < op2);
            default:  alu_res = op_a_q + op2;
        endcase
    end

    assign exec_result = is_u ? imm : alu_res;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            BR_EQ:   br_taken = (op_a_q == op_b_q);
            BR_NE:   br_taken = (op_a_q != op_b_q);
            BR_LT:   br_taken = ($signed(op_a_q) <  $signed(op_b_q));
            BR_GE:   br_taken = ($signed(op_a_q) >= $signed(op_b_q));
            default: br_taken = 1'b0;
        endcase
    end

    // ----------------------------------------------------------- controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pc       <= PC_RESET;
            hata     <= 1'b0;
            retire   <= 1'b0;
            imem_req <= 1'b0;
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr_q  <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (dec_err) begin
                        state <= ST_ERROR;
                        hata  <= 1'b1;
                    end else begin
                        op_a_q <= rs1_data;
                        op_b_q <= rs2_data;
                        state  <= ST_EXECUTE;
                    end
                end

                ST_EXECUTE: begin
                    result_q <= exec_result;
                    taken_q  <= is_b && br_taken;
                    retire   <= 1'b1;   // high for the whole WRITEBACK cycle
                    state    <= ST_WRITEBACK;
                end

                ST_WRITEBACK: begin
                    pc <= taken_q ? (pc + imm) : (pc + XLEN'(4));
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_ERROR: begin
                    hata     <= 1'b1;
                    imem_req <= 1'b0;
                end

                default: begin
                    state    <= ST_ERROR;
                    hata     <= 1'b1;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;

endmodule
